pc_redirect_ctrl: RTL

Fetch-side consumer of the branch-taken select generated in EX/MEM (Branch & zero). Owns the PC register and the instruction-memory request handshake. Applies the branch redirect, squashes wrong-path instructions in IF/ID and ID/EX, and holds the PC on load-use stalls. Sits between the hazard unit, the EX/MEM branch-resolution logic and instruction memory.

---
 rtl/pipe_pkg.sv | 21 ++
 rtl/pc_next_mux.sv | 34 +++
 rtl/pc_redirect_ctrl.sv | 114 +++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared fetch-side definitions: default widths, reset PC, instruction size,
// the fetch FSM states and the next-PC source select.
package pipe_pkg;

  localparam int          ADDR_W_DEFAULT   = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int          INSTR_BYTES      = 4;

  typedef enum logic {
    FETCH,
    DRAIN
  } fetch_state_e;

  typedef enum logic [1:0] {
    PC_HOLD,
    PC_INC,
    PC_TARGET,
    PC_PEND
  } pc_sel_e;

endpackage

// File: rtl/pc_next_mux.sv
// Combinational next-PC selection (hold / increment / redirect / pending redirect)
// plus word alignment of the incoming branch target.
module pc_next_mux
  import pipe_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT
) (
  input  pc_sel_e           i_sel,
  input  logic [ADDR_W-1:0] i_pc,
  input  logic [ADDR_W-1:0] i_target,
  input  logic [ADDR_W-1:0] i_pend,
  output logic [ADDR_W-1:0] o_targetAligned,
  output logic [ADDR_W-1:0] o_pcPlus4,
  output logic [ADDR_W-1:0] o_nextPc,
  output logic              o_misaligned
);

  // Low bits of a target are dropped rather than trapped; the top level only flags them.
  assign o_targetAligned = {i_target[ADDR_W-1:2], 2'b00};
  assign o_misaligned    = |i_target[1:0];
  assign o_pcPlus4       = i_pc + ADDR_W'(INSTR_BYTES);

  always_comb begin
    o_nextPc = i_pc;
    case (i_sel)
      PC_HOLD:   o_nextPc = i_pc;
      PC_INC:    o_nextPc = o_pcPlus4;
      PC_TARGET: o_nextPc = o_targetAligned;
      PC_PEND:   o_nextPc = i_pend;
      default:   o_nextPc = i_pc;
    endcase
  end

endmodule

// File: rtl/pc_redirect_ctrl.sv
// Owns the PC and the instruction-fetch handshake; applies branch redirects,
// squashes wrong-path instructions and holds the PC on load-use stalls.
module pc_redirect_ctrl
  import pipe_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEFAULT,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              select,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              stall,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  output logic              if_valid,
  output logic [ADDR_W-1:0] pc_out,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic              flush_if_id,
  output logic              flush_id_ex,
  output logic              misalign_err
);

  fetch_state_e      r_state;
  fetch_state_e      w_nextState;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_pend;
  logic              r_flush;
  logic              r_misalign;
  pc_sel_e           w_pcSel;
  logic              w_pendLoad;
  logic              w_ifValid;
  logic [ADDR_W-1:0] w_targetAligned;
  logic [ADDR_W-1:0] w_pcPlus4;
  logic [ADDR_W-1:0] w_nextPc;
  logic              w_misaligned;

  pc_next_mux #(.ADDR_W(ADDR_W)) u_mux (
    .i_sel           (w_pcSel),
    .i_pc            (r_pc),
    .i_target        (branch_target),
    .i_pend          (r_pend),
    .o_targetAligned (w_targetAligned),
    .o_pcPlus4       (w_pcPlus4),
    .o_nextPc        (w_nextPc),
    .o_misaligned    (w_misaligned)
  );

  // A redirect that arrives while a fetch is still outstanding keeps the old
  // address on the bus and parks the target until the memory completes.
  always_comb begin
    w_nextState = r_state;
    w_pcSel     = PC_HOLD;
    w_pendLoad  = 1'b0;
    w_ifValid   = 1'b0;
    case (r_state)
      FETCH: begin
        if (select) begin
          if (imem_ready) begin
            w_pcSel = PC_TARGET;
          end else begin
            w_nextState = DRAIN;
            w_pendLoad  = 1'b1;
          end
        end else if (imem_ready && !stall) begin
          w_pcSel   = PC_INC;
          w_ifValid = 1'b1;
        end
      end
      DRAIN: begin
        if (select) begin
          if (imem_ready) begin
            w_pcSel     = PC_TARGET;
            w_nextState = FETCH;
          end else begin
            w_pendLoad = 1'b1;
          end
        end else if (imem_ready) begin
          w_pcSel     = PC_PEND;
          w_nextState = FETCH;
        end
      end
      default: w_nextState = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= FETCH;
      r_pc       <= RESET_PC;
      r_pend     <= '0;
      r_flush    <= 1'b0;
      r_misalign <= 1'b0;
    end else begin
      r_state <= w_nextState;
      r_pc    <= w_nextPc;
      r_flush <= select;
      if (w_pendLoad) r_pend <= w_targetAligned;
      if (select && w_misaligned) r_misalign <= 1'b1;
    end
  end

  // Reset masks the request and the squash pulses within the reset cycle itself.
  assign imem_req     = ~reset;
  assign imem_addr    = r_pc;
  assign if_valid     = w_ifValid & ~reset;
  assign pc_out       = r_pc;
  assign pc_plus4     = w_pcPlus4;
  assign flush_if_id  = r_flush & ~reset;
  assign flush_id_ex  = r_flush & ~reset;
  assign misalign_err = r_misalign;

endmodule
